// File: rtl/wdt_timer.sv
// wdt_timer: watchdog timer with a single-cycle register slave port.
//
// Counts prescaled clock ticks while enabled and raises a level `timeout`
// once the count reaches the programmed threshold. The level holds until
// software kicks (WDLIVE) or disables (WDEN) the watchdog. Masking and
// acknowledgement of the request are handled downstream.
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset, overrides any same-cycle access
//   wdt_wen     register write strobe
//   wdt_ren     register read strobe
//   wdt_addr    register offset, shared by read and write
//   wdt_wdata   write data
//   wdt_rdata   registered read data, holds its value while wdt_rvalid is low
//   wdt_rvalid  one-cycle pulse marking wdt_rdata valid
//   timeout     watchdog expired, registered level
//
// Register map
//   0x0100 WDEN    RW  bit0 enable
//   0x0200 WDLIVE  WO  bit0=1 kicks, reads 0
//   0x0300 WTOCNT  RW  threshold
//   0x0400 WDCNT   RO  current count
//   0x0500 STATUS  RO  {30'b0, state}
//
// CNT_W must not exceed the 32-bit bus width.

module wdt_timer #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wdt_wen,
    input  logic        wdt_ren,
    input  logic [15:0] wdt_addr,
    input  logic [31:0] wdt_wdata,
    output logic [31:0] wdt_rdata,
    output logic        wdt_rvalid,
    output logic        timeout
);

    localparam logic [15:0] AddrWden   = 16'h0100;
    localparam logic [15:0] AddrWdlive = 16'h0200;
    localparam logic [15:0] AddrWtocnt = 16'h0300;
    localparam logic [15:0] AddrWdcnt  = 16'h0400;
    localparam logic [15:0] AddrStatus = 16'h0500;

    localparam int unsigned     PreW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCount   = 2'b01,
        StExpired = 2'b10
    } state_e;

    state_e            state_q;
    logic              wden_q;
    logic [CNT_W-1:0]  wtocnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PreW-1:0]   pre_q;
    logic              timeout_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;
    logic              rvalid_q;

    logic wr_wden;
    logic wr_tocnt;
    logic en_set;
    logic en_clr;
    logic kick;
    logic tick;

    // Write decode; a WDLIVE write with bit0=0 is not a kick.
    assign wr_wden  = wdt_wen && (wdt_addr == AddrWden);
    assign wr_tocnt = wdt_wen && (wdt_addr == AddrWtocnt);
    assign en_set   = wr_wden && wdt_wdata[0];
    assign en_clr   = wr_wden && !wdt_wdata[0];
    assign kick     = wdt_wen && (wdt_addr == AddrWdlive) && wdt_wdata[0];
    assign tick     = (pre_q == PreMax);

    // Watchdog state machine and its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wden_q    <= 1'b0;
            wtocnt_q  <= '0;
            cnt_q     <= '0;
            pre_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (wr_wden) begin
                wden_q <= wdt_wdata[0];
            end
            if (wr_tocnt) begin
                wtocnt_q <= wdt_wdata[CNT_W-1:0];
            end

            case (state_q)
                StIdle: begin
                    cnt_q     <= '0;
                    pre_q     <= '0;
                    timeout_q <= 1'b0;
                    if (en_set) begin
                        state_q <= StCount;
                    end
                end

                StCount: begin
                    if (en_clr) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        pre_q   <= '0;
                    end else if (kick) begin
                        // A kick suppresses the tick of the same cycle.
                        cnt_q <= '0;
                        pre_q <= '0;
                    end else if (tick) begin
                        pre_q <= '0;
                        // >= lets a lowered threshold expire on the next tick
                        // and keeps cnt from ever wrapping past all-ones.
                        if (cnt_q >= wtocnt_q) begin
                            state_q   <= StExpired;
                            timeout_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end

                StExpired: begin
                    // cnt stays frozen; re-enabling has no effect here.
                    if (en_clr) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        pre_q     <= '0;
                        timeout_q <= 1'b0;
                    end else if (kick) begin
                        state_q   <= StCount;
                        cnt_q     <= '0;
                        pre_q     <= '0;
                        timeout_q <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    pre_q     <= '0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    // Read mux samples pre-edge state, so a same-cycle write returns the old value.
    always_comb begin
        rdata_d = '0;
        case (wdt_addr)
            AddrWden:   rdata_d = {31'b0, wden_q};
            AddrWtocnt: rdata_d = 32'(wtocnt_q);
            AddrWdcnt:  rdata_d = 32'(cnt_q);
            AddrStatus: rdata_d = {30'b0, state_q};
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= wdt_ren;
            if (wdt_ren) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign wdt_rdata  = rdata_q;
    assign wdt_rvalid = rvalid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_wdt_timer.sv
// Bench for wdt_timer: two instances (PRESCALE=1 and PRESCALE=4) share one bus
// driver selected by `sel`. Expected read data is queued when a read is issued
// and compared when wdt_rvalid is seen.

module tb_wdt_timer;

    localparam logic [15:0] AddrWden   = 16'h0100;
    localparam logic [15:0] AddrWdlive = 16'h0200;
    localparam logic [15:0] AddrWtocnt = 16'h0300;
    localparam logic [15:0] AddrWdcnt  = 16'h0400;
    localparam logic [15:0] AddrStatus = 16'h0500;
    localparam logic [15:0] AddrBad    = 16'h0700;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic        ren;
    logic        sel;
    logic [15:0] addr;
    logic [31:0] wdata;

    logic        wen0, wen1, ren0, ren1;
    logic [31:0] rdata0, rdata1, rdata_s;
    logic        rvalid0, rvalid1, rvalid_s;
    logic        timeout0, timeout1, timeout_s;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    exp_t exp_v;

    always #5 clk = ~clk;

    assign wen0      = wen & ~sel;
    assign wen1      = wen & sel;
    assign ren0      = ren & ~sel;
    assign ren1      = ren & sel;
    assign rdata_s   = sel ? rdata1 : rdata0;
    assign rvalid_s  = sel ? rvalid1 : rvalid0;
    assign timeout_s = sel ? timeout1 : timeout0;

    wdt_timer #(.CNT_W(32), .PRESCALE(1)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .wdt_wen    (wen0),
        .wdt_ren    (ren0),
        .wdt_addr   (addr),
        .wdt_wdata  (wdata),
        .wdt_rdata  (rdata0),
        .wdt_rvalid (rvalid0),
        .timeout    (timeout0)
    );

    wdt_timer #(.CNT_W(32), .PRESCALE(4)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .wdt_wen    (wen1),
        .wdt_ren    (ren1),
        .wdt_addr   (addr),
        .wdt_wdata  (wdata),
        .wdt_rdata  (rdata1),
        .wdt_rvalid (rvalid1),
        .timeout    (timeout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endfunction

    // Scoreboard: every rvalid pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (rvalid_s) begin
            if (exp_q.size() == 0) begin
                check("rd_spurious", {31'b0, rvalid_s}, 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                check(exp_v.tag, rdata_s, exp_v.val);
            end
        end
    end

    // All bus tasks start and end on a negedge; each access takes one cycle.
    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        wen   = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] e, input string tag);
        ren  = 1'b1;
        addr = a;
        push(tag, e);
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sel(input logic v);
        @(negedge clk);
        sel = v;
        @(negedge clk);
    endtask

    // Enable with threshold n and track count/timeout every cycle against
    // cnt(k) = min((k-1)/p, n), timeout from cycle p*(n+1)+1.
    task automatic run_expiry(input int n, input int p);
        int lim;
        int rise;
        int c;
        rise = p * (n + 1) + 1;
        lim  = rise + 1;
        wr(AddrWtocnt, 32'(n));
        wr(AddrWden, 32'd1);
        for (int k = 1; k <= lim; k++) begin
            check("exp_timeout", {31'b0, timeout_s}, 32'(k >= rise));
            c = (k - 1) / p;
            if (c > n) c = n;
            ren  = 1'b1;
            addr = AddrWdcnt;
            push("exp_wdcnt", 32'(c));
            @(negedge clk);
        end
        ren = 1'b0;
        rd(AddrStatus, 32'd2, "exp_status");
        idle(4);
        rd(AddrWdcnt, 32'(n), "exp_cnt_frozen");
        check("exp_timeout_hold", {31'b0, timeout_s}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        sel   = 1'b0;
        addr  = '0;
        wdata = '0;
        idle(2);
        check("rst_timeout0", {31'b0, timeout0}, 32'd0);
        check("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
        check("rst_timeout1", {31'b0, timeout1}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        rst = 1'b0;
        rd(AddrStatus, 32'd0, "rst_status");
        rd(AddrWdcnt, 32'd0, "rst_wdcnt");
        rd(AddrWtocnt, 32'd0, "rst_wtocnt");
        rd(AddrWden, 32'd0, "rst_wden");

        // Expiry at PRESCALE=1, threshold 5.
        run_expiry(5, 1);

        // Recovery by kick, then disable.
        wr(AddrWdlive, 32'd1);
        check("rec_timeout", {31'b0, timeout0}, 32'd0);
        rd(AddrWdcnt, 32'd0, "rec_wdcnt");
        rd(AddrStatus, 32'd1, "rec_status_count");
        wr(AddrWden, 32'd0);
        rd(AddrStatus, 32'd0, "rec_status_idle");
        rd(AddrWdcnt, 32'd0, "rec_wdcnt_idle");

        // Regular kicks keep the watchdog from expiring.
        wr(AddrWtocnt, 32'd10);
        wr(AddrWden, 32'd1);
        for (int i = 0; i < 200; i++) begin
            wen   = (i % 8 == 0);
            addr  = AddrWdlive;
            wdata = 32'd1;
            check("kick_timeout", {31'b0, timeout0}, 32'd0);
            @(negedge clk);
        end
        wen = 1'b0;
        rd(AddrStatus, 32'd1, "kick_status");
        wr(AddrWden, 32'd0);

        // Lowered threshold while counting.
        wr(AddrWtocnt, 32'd100);
        wr(AddrWden, 32'd1);
        idle(19);
        rd(AddrWdcnt, 32'd19, "low_wdcnt");
        wr(AddrWtocnt, 32'd3);
        check("low_timeout_pre", {31'b0, timeout0}, 32'd0);
        @(negedge clk);
        check("low_timeout", {31'b0, timeout0}, 32'd1);
        rd(AddrWdcnt, 32'd21, "low_wdcnt_frozen");
        rd(AddrStatus, 32'd2, "low_status");
        wr(AddrWden, 32'd0);
        check("low_timeout_clr", {31'b0, timeout0}, 32'd0);

        // Reset mid-count overrides a same-cycle write and read.
        wr(AddrWtocnt, 32'd50);
        wr(AddrWden, 32'd1);
        idle(5);
        rst   = 1'b1;
        wen   = 1'b1;
        ren   = 1'b1;
        addr  = AddrWtocnt;
        wdata = 32'd77;
        @(negedge clk);
        check("mrst_rvalid_a", {31'b0, rvalid0}, 32'd0);
        @(negedge clk);
        check("mrst_rvalid_b", {31'b0, rvalid0}, 32'd0);
        rst = 1'b0;
        wen = 1'b0;
        ren = 1'b0;
        check("mrst_timeout", {31'b0, timeout0}, 32'd0);
        rd(AddrStatus, 32'd0, "mrst_status");
        rd(AddrWdcnt, 32'd0, "mrst_wdcnt");
        rd(AddrWtocnt, 32'd0, "mrst_wtocnt");
        rd(AddrWden, 32'd0, "mrst_wden");

        // Bus corner cases.
        rd(AddrBad, 32'd0, "bus_unmapped");
        @(negedge clk);
        check("bus_rvalid_pulse", {31'b0, rvalid0}, 32'd0);
        wr(AddrWtocnt, 32'd4);
        wen   = 1'b1;
        ren   = 1'b1;
        addr  = AddrWtocnt;
        wdata = 32'd9;
        push("bus_rw_old", 32'd4);
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
        rd(AddrWtocnt, 32'd9, "bus_rw_new");
        @(negedge clk);
        check("bus_rdata_hold", rdata0, 32'd9);
        wr(AddrBad, 32'd5);
        rd(AddrWtocnt, 32'd9, "bus_bad_write");
        wr(AddrWdlive, 32'd1);
        rd(AddrWdlive, 32'd0, "bus_wdlive_read");
        rd(AddrStatus, 32'd0, "bus_idle_kick");

        // PRESCALE=4 instance.
        set_sel(1'b1);
        run_expiry(3, 4);
        wr(AddrWden, 32'd0);
        check("pre4_timeout_clr", {31'b0, timeout_s}, 32'd0);

        idle(3);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
